c499_key_seq: RTL

C499_KEY_SEQ -- requirements
Module: c499_key_seq

---
 rtl/c499_key_seq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/c499_key_seq.sv
// Key loader and request sequencer for the c499 locked core.
// Ports:
//   CK, RST                  clock, async active-high reset
//   key_sin/sen/commit/clear serial key load and control
//   key_out, key_valid       committed key to the core
//   key_err                  one-cycle pulse on premature commit
//   req_valid/ready/data/chk/en  request handshake in
//   core_in / core_out       registered core stimulus / core result
//   resp_valid/ready/data/corrected  response handshake out
module c499_key_seq #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        key_sin,
    input  logic        key_sen,
    input  logic        key_commit,
    input  logic        key_clear,
    output logic [10:0] key_out,
    output logic        key_valid,
    output logic        key_err,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [7:0]  req_chk,
    input  logic        req_en,
    output logic [40:0] core_in,
    input  logic [31:0] core_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_corrected
);

    typedef enum logic [1:0] {
        KEYLOAD = 2'd0,
        IDLE    = 2'd1,
        SETTLE  = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_BITS  = 4'd11;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    state_t      state_q;
    state_t      state_d;

    logic [10:0] shadow_q;
    logic [10:0] shadow_d;
    logic [3:0]  bitcnt_q;
    logic [3:0]  bitcnt_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [10:0] key_out_q;
    logic [10:0] key_out_d;
    logic        key_valid_q;
    logic        key_valid_d;
    logic        key_err_q;
    logic        key_err_d;
    logic [40:0] core_in_q;
    logic [40:0] core_in_d;
    logic [31:0] resp_data_q;
    logic [31:0] resp_data_d;
    logic        resp_corr_q;
    logic        resp_corr_d;
    logic        resp_valid_q;
    logic        resp_valid_d;

    // Event decode, all derived from the current state and inputs.
    logic        in_keyload;
    logic        in_idle;
    logic        in_settle;
    logic        in_resp;
    logic        key_full;
    logic        do_shift;
    logic        do_commit;
    logic        commit_early;
    logic        do_clear;
    logic        do_accept;
    logic        do_sample;
    logic        resp_done;

    always_comb begin
        in_keyload   = (state_q == KEYLOAD);
        in_idle      = (state_q == IDLE);
        in_settle    = (state_q == SETTLE);
        in_resp      = (state_q == RESP);
        key_full     = (bitcnt_q == KEY_BITS);
        do_shift     = in_keyload && key_sen;
        // A commit that coincides with a shift is treated as a shift only.
        do_commit    = in_keyload && key_commit && !key_sen && key_full;
        commit_early = in_keyload && key_commit && !key_sen && !key_full;
        // Clear wins over a simultaneous request.
        do_clear     = in_idle && key_clear;
        do_accept    = in_idle && !key_clear && req_valid;
        do_sample    = in_settle && (cnt_q <= 4'd1);
        resp_done    = in_resp && resp_ready;
    end

    // State register.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= KEYLOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KEYLOAD: begin
                if (do_commit) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (do_clear) begin
                    state_d = KEYLOAD;
                end else if (do_accept) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (do_sample) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Datapath next-state logic.
    always_comb begin
        shadow_d     = shadow_q;
        bitcnt_d     = bitcnt_q;
        cnt_d        = cnt_q;
        key_out_d    = key_out_q;
        key_valid_d  = key_valid_q;
        key_err_d    = 1'b0;
        core_in_d    = core_in_q;
        resp_data_d  = resp_data_q;
        resp_corr_d  = resp_corr_q;
        resp_valid_d = resp_valid_q;

        if (do_shift) begin
            shadow_d = {shadow_q[9:0], key_sin};
            if (!key_full) begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end

        if (do_commit) begin
            key_out_d   = shadow_q;
            key_valid_d = 1'b1;
        end

        if (commit_early) begin
            key_err_d = 1'b1;
        end

        if (do_clear) begin
            shadow_d    = '0;
            bitcnt_d    = '0;
            key_out_d   = '0;
            key_valid_d = 1'b0;
        end

        if (do_accept) begin
            core_in_d = {req_en, req_chk, req_data};
            cnt_d     = SETTLE_LD;
        end

        if (in_settle) begin
            if (do_sample) begin
                resp_data_d  = core_out;
                resp_corr_d  = (core_out != core_in_q[31:0]);
                resp_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        if (resp_done) begin
            resp_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            shadow_q     <= '0;
            bitcnt_q     <= '0;
            cnt_q        <= '0;
            key_out_q    <= '0;
            key_valid_q  <= 1'b0;
            key_err_q    <= 1'b0;
            core_in_q    <= '0;
            resp_data_q  <= '0;
            resp_corr_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            bitcnt_q     <= bitcnt_d;
            cnt_q        <= cnt_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            key_err_q    <= key_err_d;
            core_in_q    <= core_in_d;
            resp_data_q  <= resp_data_d;
            resp_corr_q  <= resp_corr_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Outputs.
    always_comb begin
        req_ready      = in_idle && !key_clear;
        key_out        = key_out_q;
        key_valid      = key_valid_q;
        key_err        = key_err_q;
        core_in        = core_in_q;
        resp_valid     = resp_valid_q;
        resp_data      = resp_data_q;
        resp_corrected = resp_corr_q;
    end

endmodule
